// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with maximal-length taps, seed load with zero-lock
// protection, an autonomous N-step burst mode and a period-wrap flag.
module lfsr_gen #(
    parameter int unsigned       WIDTH      = 4,
    parameter logic [WIDTH-1:0]  RESET_SEED = WIDTH'(1),
    parameter int unsigned       CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              start,
    input  logic [CNT_W-1:0]  nsteps,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  data_out,
    output logic              bit_out,
    output logic              wrap,
    output logic              seed_err
);

    if (WIDTH < 3 || WIDTH > 16) begin : g_width_chk
        $error("lfsr_gen: WIDTH must be in 3..16");
    end
    if (RESET_SEED == '0) begin : g_seed_chk
        $error("lfsr_gen: RESET_SEED must be non-zero");
    end

    function automatic logic [15:0] tap_mask(input int unsigned w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]      TAPS_FULL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= RESET_SEED;
            fsm      <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            seed_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            wrap     <= 1'b0;
            seed_err <= 1'b0;
            if (load) begin
                // Zero would lock the register, so it is replaced by 1 and flagged.
                if (seed == '0) begin
                    lfsr     <= WIDTH'(1);
                    seed_err <= 1'b1;
                end else begin
                    lfsr <= seed;
                end
                fsm  <= IDLE;
                cnt  <= '0;
                busy <= 1'b0;
            end else if (fsm == RUN) begin
                lfsr <= lfsr_next;
                wrap <= (lfsr_next == RESET_SEED);
                cnt  <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                if (nsteps != '0) begin
                    cnt  <= nsteps;
                    fsm  <= RUN;
                    busy <= 1'b1;
                end else begin
                    done <= 1'b1;
                end
            end else if (en) begin
                lfsr <= lfsr_next;
                wrap <= (lfsr_next == RESET_SEED);
            end
        end
    end

    assign data_out = lfsr;
    assign bit_out  = lfsr[WIDTH-1];

endmodule
